// File: rtl/pla_prog_eval_if.sv
// Bundle of the config, input-stream and output-stream signals of the
// programmable PLA evaluator. The master side drives config and input vectors
// and consumes results; the slave side is the evaluator itself.
//
// Handshake rules, shared by every channel in this bundle:
//   A transfer happens on a rising clock edge where both valid and ready are
//   high. After the producer raises valid, it holds valid and the payload
//   unchanged until the transfer happens. The consumer may raise or lower
//   ready at any time. On the config channel, cfg_we plays the role of valid.
//   A write that sees cfg_ready low is dropped rather than held pending.
interface pla_prog_eval_if #(
   parameter int N_IN    = 33,
   parameter int N_OUT   = 23,
   parameter int N_TERMS = 64
);
   localparam int TW = $clog2(N_TERMS);
   localparam int CW = $clog2(N_TERMS + 1);

   // config port
   logic              cfg_we;
   logic [1:0]        cfg_sel;
   logic [TW-1:0]     cfg_addr;
   logic [N_IN-1:0]   cfg_care;
   logic [N_IN-1:0]   cfg_val;
   logic [N_OUT-1:0]  cfg_or;
   logic              cfg_ten;
   logic              cfg_ready;

   // input stream
   logic              in_valid;
   logic              in_ready;
   logic [N_IN-1:0]   in_data;

   // output stream
   logic              out_valid;
   logic              out_ready;
   logic [N_OUT-1:0]  out_data;
   logic [CW-1:0]     out_hits;

   modport master (
      output cfg_we, cfg_sel, cfg_addr, cfg_care, cfg_val, cfg_or, cfg_ten,
      input  cfg_ready,
      output in_valid, in_data,
      input  in_ready,
      input  out_valid, out_data, out_hits,
      output out_ready
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_addr, cfg_care, cfg_val, cfg_or, cfg_ten,
      output cfg_ready,
      input  in_valid, in_data,
      output in_ready,
      output out_valid, out_data, out_hits,
      input  out_ready
   );
endinterface

// File: rtl/pla_prog_eval.sv
// Runtime-programmable two-level (AND/OR) logic evaluator.
// The AND plane (care/val/ten per term), the OR plane and the output invert mask
// live in registers that are written over the config port. Input vectors stream
// through a two-stage pipeline: S1 captures the product-term match vector,
// S2 captures the OR-plane result (with output phase applied) and the hit count.
module pla_prog_eval #(
   parameter int N_IN    = 33,
   parameter int N_OUT   = 23,
   parameter int N_TERMS = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   pla_prog_eval_if.slave    bus
);
   localparam int TW = $clog2(N_TERMS);
   localparam int CW = $clog2(N_TERMS + 1);

   localparam logic [1:0] SEL_AND = 2'd0;
   localparam logic [1:0] SEL_OR  = 2'd1;
   localparam logic [1:0] SEL_INV = 2'd2;

   // ---------------------------------------------------------------------------
   // Plane storage
   // ---------------------------------------------------------------------------
   logic [N_IN-1:0]    care_q [N_TERMS];
   logic [N_IN-1:0]    care_d [N_TERMS];
   logic [N_IN-1:0]    val_q  [N_TERMS];
   logic [N_IN-1:0]    val_d  [N_TERMS];
   logic [N_OUT-1:0]   or_q   [N_TERMS];
   logic [N_OUT-1:0]   or_d   [N_TERMS];
   logic [N_TERMS-1:0] ten_q;
   logic [N_TERMS-1:0] ten_d;
   logic [N_OUT-1:0]   inv_q;
   logic [N_OUT-1:0]   inv_d;

   // ---------------------------------------------------------------------------
   // Pipeline state
   // ---------------------------------------------------------------------------
   logic               s1_valid_q;
   logic               s1_valid_d;
   logic [N_TERMS-1:0] s1_match_q;
   logic [N_TERMS-1:0] s1_match_d;
   logic               s2_valid_q;
   logic               s2_valid_d;
   logic [N_OUT-1:0]   out_data_q;
   logic [N_OUT-1:0]   out_data_d;
   logic [CW-1:0]      out_hits_q;
   logic [CW-1:0]      out_hits_d;

   // ---------------------------------------------------------------------------
   // Handshake / control signals
   // ---------------------------------------------------------------------------
   logic               s2_adv;
   logic               s1_adv;
   logic               in_ready;
   logic               in_fire;
   logic               cfg_ready;
   logic               addr_ok;
   logic               wr_and;
   logic               wr_or;
   logic               wr_inv;

   // Datapath intermediates
   logic [N_TERMS-1:0] match_now;
   logic [N_OUT-1:0]   or_acc;
   logic [CW-1:0]      hit_cnt;

   // Stage advance, input acceptance and config write qualification.
   // Config may only land while nothing is in flight and nothing is being
   // offered, so every vector in the pipeline sees one consistent set of planes.
   always_comb begin
      s2_adv    = ~s2_valid_q | bus.out_ready;
      s1_adv    = ~s1_valid_q | s2_adv;
      in_ready  = s1_adv & ~bus.cfg_we;
      in_fire   = bus.in_valid & in_ready;
      cfg_ready = ~s1_valid_q & ~s2_valid_q & ~bus.in_valid;
      // Only matters when N_TERMS is not a power of two; out-of-range rows are dropped.
      addr_ok   = (int'(bus.cfg_addr) < N_TERMS);
      wr_and    = bus.cfg_we & cfg_ready & (bus.cfg_sel == SEL_AND) & addr_ok;
      wr_or     = bus.cfg_we & cfg_ready & (bus.cfg_sel == SEL_OR)  & addr_ok;
      wr_inv    = bus.cfg_we & cfg_ready & (bus.cfg_sel == SEL_INV);
   end

   // Next-state of the AND/OR planes and the invert mask; sel 3 writes nothing.
   always_comb begin
      care_d = care_q;
      val_d  = val_q;
      or_d   = or_q;
      ten_d  = ten_q;
      inv_d  = inv_q;
      if (wr_and) begin
         care_d[bus.cfg_addr] = bus.cfg_care;
         val_d[bus.cfg_addr]  = bus.cfg_val;
         ten_d[bus.cfg_addr]  = bus.cfg_ten;
      end
      if (wr_or) begin
         or_d[bus.cfg_addr] = bus.cfg_or;
      end
      if (wr_inv) begin
         inv_d = bus.cfg_or;
      end
   end

   // AND plane: a term matches when enabled and every cared-for literal agrees.
   always_comb begin
      match_now = '0;
      for (int t = 0; t < N_TERMS; t++) begin
         match_now[t] = ten_q[t] & ~(|((bus.in_data ^ val_q[t]) & care_q[t]));
      end
   end

   // S1 next-state: match vector is only reloaded on an accepted vector so it
   // does not toggle on idle or stalled cycles.
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_match_d = s1_match_q;
      if (s1_adv) begin
         s1_valid_d = in_fire;
         if (in_fire) begin
            s1_match_d = match_now;
         end
      end
   end

   // OR plane and hit count over the registered match vector.
   always_comb begin
      or_acc  = '0;
      hit_cnt = '0;
      for (int t = 0; t < N_TERMS; t++) begin
         if (s1_match_q[t]) begin
            or_acc  = or_acc | or_q[t];
            hit_cnt = hit_cnt + CW'(1);
         end
      end
   end

   // S2 next-state: result registers hold while the downstream stalls.
   always_comb begin
      s2_valid_d = s2_valid_q;
      out_data_d = out_data_q;
      out_hits_d = out_hits_q;
      if (s2_adv) begin
         s2_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_data_d = or_acc ^ inv_q;
            out_hits_d = hit_cnt;
         end
      end
   end

   // All state: planes and pipeline, cleared asynchronously so in-flight
   // vectors are dropped and no stale result can appear after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int t = 0; t < N_TERMS; t++) begin
            care_q[t] <= '0;
            val_q[t]  <= '0;
            or_q[t]   <= '0;
         end
         ten_q      <= '0;
         inv_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_match_q <= '0;
         s2_valid_q <= 1'b0;
         out_data_q <= '0;
         out_hits_q <= '0;
      end else begin
         care_q     <= care_d;
         val_q      <= val_d;
         or_q       <= or_d;
         ten_q      <= ten_d;
         inv_q      <= inv_d;
         s1_valid_q <= s1_valid_d;
         s1_match_q <= s1_match_d;
         s2_valid_q <= s2_valid_d;
         out_data_q <= out_data_d;
         out_hits_q <= out_hits_d;
      end
   end

   // Port outputs
   assign bus.cfg_ready = cfg_ready;
   assign bus.in_ready  = in_ready;
   assign bus.out_valid = s2_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_hits  = out_hits_q;

endmodule

// File: tb/tb_pla_prog_eval.sv
// Directed bench for the programmable PLA evaluator: reset state, single-term
// and constant-term behaviour, output inversion, streaming with backpressure,
// config gating while busy, and reset with vectors in flight.
module tb_pla_prog_eval;
   localparam int N_IN    = 33;
   localparam int N_OUT   = 23;
   localparam int N_TERMS = 64;

   logic clk;
   logic rst_n;

   int checks;
   int errors;

   // expected {hits, z} for streamed vectors
   logic [6+N_OUT:0] exp_q[$];

   pla_prog_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) bus ();

   pla_prog_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .N_TERMS(N_TERMS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hand-derived result for the planes loaded before the streaming step:
   //   term0  : x[0]==1          -> z[5]
   //   term2  : x[32]==1         -> z[22], z[1]
   //   term63 : x[2:1]==2'b01    -> z[8]
   function automatic logic [6+N_OUT:0] model_t4(input logic [N_IN-1:0] x);
      logic [N_OUT-1:0] z;
      logic [6:0]       h;
      logic [1:0]       f;
      z = '0;
      h = '0;
      f = x[2:1];
      if (x[0])        begin z = z | 23'h000020; h = h + 7'd1; end
      if (x[32])       begin z = z | 23'h400002; h = h + 7'd1; end
      if (f == 2'b01)  begin z = z | 23'h000100; h = h + 7'd1; end
      return {h, z};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic cfg_write(input logic [1:0] sel, input logic [5:0] addr,
                            input logic [N_IN-1:0] care, input logic [N_IN-1:0] val,
                            input logic [N_OUT-1:0] orv, input logic ten);
      for (int i = 0; i < 10 && bus.cfg_ready !== 1'b1; i++) tick();
      chk("cfg_ready_idle", 64'(bus.cfg_ready), 64'd1);
      bus.cfg_we   = 1'b1;
      bus.cfg_sel  = sel;
      bus.cfg_addr = addr;
      bus.cfg_care = care;
      bus.cfg_val  = val;
      bus.cfg_or   = orv;
      bus.cfg_ten  = ten;
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic send_vec(input logic [N_IN-1:0] x);
      bus.in_valid = 1'b1;
      bus.in_data  = x;
      #1;
      chk("in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(input string tag, input logic [N_OUT-1:0] z, input logic [6:0] h);
      for (int i = 0; i < 10 && bus.out_valid !== 1'b1; i++) tick();
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
      chk({tag, "_z"},     64'(bus.out_data),  64'(z));
      chk({tag, "_hits"},  64'(bus.out_hits),  64'(h));
      tick();
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [N_IN-1:0]  vecs [8];
      logic [6+N_OUT:0] exp_e;
      logic [N_OUT-1:0] prev_data;
      logic [6:0]       prev_hits;
      logic             prev_stall;
      logic             saw_block;
      logic             saw_valid;
      int               sent;
      int               got;

      checks = 0;
      errors = 0;
      rst_n         = 1'b0;
      bus.cfg_we    = 1'b0;
      bus.cfg_sel   = '0;
      bus.cfg_addr  = '0;
      bus.cfg_care  = '0;
      bus.cfg_val   = '0;
      bus.cfg_or    = '0;
      bus.cfg_ten   = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);
      chk("rst_out_hits",  64'(bus.out_hits),  64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("idle_cfg_ready", 64'(bus.cfg_ready), 64'd1);

      // 1. exact two-cycle latency with empty planes
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h1_2345_6789;
      #1;
      chk("t1_in_ready", 64'(bus.in_ready), 64'd1);
      chk("t1_valid_c0", 64'(bus.out_valid), 64'd0);
      tick();
      bus.in_valid = 1'b0;
      chk("t1_valid_c1", 64'(bus.out_valid), 64'd0);
      tick();
      chk("t1_valid_c2", 64'(bus.out_valid), 64'd1);
      chk("t1_z",        64'(bus.out_data),  64'd0);
      chk("t1_hits",     64'(bus.out_hits),  64'd0);
      tick();
      chk("t1_valid_c3", 64'(bus.out_valid), 64'd0);

      // 2. one literal term and one constant-1 term
      cfg_write(2'd0, 6'd0, 33'h1, 33'h1, '0, 1'b1);
      cfg_write(2'd1, 6'd0, '0, '0, 23'h000020, 1'b0);
      cfg_write(2'd0, 6'd1, '0, '0, '0, 1'b1);
      cfg_write(2'd1, 6'd1, '0, '0, 23'h000001, 1'b0);
      send_vec(33'h0_0000_0001);
      wait_result("t2_x1", 23'h21, 7'd2);
      send_vec(33'h1_FFFF_FFFE);
      wait_result("t2_x0", 23'h01, 7'd1);

      // 3. full inversion with all terms disabled
      cfg_write(2'd0, 6'd0, '0, '0, '0, 1'b0);
      cfg_write(2'd0, 6'd1, '0, '0, '0, 1'b0);
      cfg_write(2'd2, 6'd0, '0, '0, 23'h7FFFFF, 1'b0);
      send_vec(33'h1_FFFF_FFFF);
      wait_result("t3_ones", 23'h7FFFFF, 7'd0);
      send_vec(33'h0_0000_0000);
      wait_result("t3_zero", 23'h7FFFFF, 7'd0);

      // 4. planes for streaming, including the last row
      cfg_write(2'd2, 6'd0, '0, '0, '0, 1'b0);
      cfg_write(2'd0, 6'd0, 33'h1, 33'h1, '0, 1'b1);
      cfg_write(2'd0, 6'd2, 33'h1_0000_0000, 33'h1_0000_0000, '0, 1'b1);
      cfg_write(2'd1, 6'd2, '0, '0, 23'h400002, 1'b0);
      cfg_write(2'd0, 6'd63, 33'h6, 33'h2, '0, 1'b1);
      cfg_write(2'd1, 6'd63, '0, '0, 23'h000100, 1'b0);

      vecs[0] = 33'h0_0000_0001;
      vecs[1] = 33'h1_0000_0000;
      vecs[2] = 33'h1_0000_0003;
      vecs[3] = 33'h0_0000_0002;
      vecs[4] = 33'h1_FFFF_FFFF;
      vecs[5] = 33'h0_0000_0000;
      vecs[6] = 33'h1_0000_0002;
      vecs[7] = 33'h0_ABCD_EF13;
      sent = 0;
      got = 0;
      prev_stall = 1'b0;
      prev_data = '0;
      prev_hits = '0;
      saw_block = 1'b0;
      for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
         bus.out_ready = !(cyc >= 4 && cyc <= 6);
         bus.in_valid  = (sent < 8);
         bus.in_data   = (sent < 8) ? vecs[sent] : '0;
         #1;
         if (prev_stall) begin
            chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("t4_hold_z",     64'(bus.out_data),  64'(prev_data));
            chk("t4_hold_hits",  64'(bus.out_hits),  64'(prev_hits));
         end
         if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model_t4(bus.in_data));
            sent++;
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               chk("t4_unexpected_out", 64'd1, 64'd0);
            end else begin
               exp_e = exp_q.pop_front();
               chk("t4_z",    64'(bus.out_data), 64'(exp_e[N_OUT-1:0]));
               chk("t4_hits", 64'(bus.out_hits), 64'(exp_e[6+N_OUT:N_OUT]));
            end
            got++;
         end
         prev_stall = bus.out_valid && !bus.out_ready;
         prev_data  = bus.out_data;
         prev_hits  = bus.out_hits;
         tick();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      chk("t4_sent",     64'(sent), 64'd8);
      chk("t4_received", 64'(got), 64'd8);
      chk("t4_leftover", 64'(exp_q.size()), 64'd0);
      chk("t4_in_ready_dropped", 64'(saw_block), 64'd1);

      // 5. config refused while busy; retried write lands after drain
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h0_0000_0001;
      #1;
      chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b1;
      bus.cfg_sel  = 2'd2;
      bus.cfg_or   = 23'h7FFFFF;
      #1;
      chk("t5_cfg_ready_busy", 64'(bus.cfg_ready), 64'd0);
      chk("t5_in_ready_cfg",   64'(bus.in_ready),  64'd0);
      tick();
      bus.cfg_we = 1'b0;
      wait_result("t5_old", 23'h000020, 7'd1);
      for (int i = 0; i < 4; i++) tick();
      // write offered together with an input vector: both held off
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h0_0000_0001;
      bus.cfg_we   = 1'b1;
      #1;
      chk("t5_cfg_ready_inv", 64'(bus.cfg_ready), 64'd0);
      chk("t5_in_ready_we",   64'(bus.in_ready),  64'd0);
      tick();
      bus.in_valid = 1'b0;
      bus.cfg_we   = 1'b0;
      // sel 3 is not a plane
      cfg_write(2'd3, 6'd0, 33'h1_FFFF_FFFF, '0, 23'h7FFFFF, 1'b0);
      send_vec(33'h0_0000_0001);
      wait_result("t5_still_old", 23'h000020, 7'd1);
      cfg_write(2'd2, 6'd0, '0, '0, 23'h7FFFFF, 1'b0);
      send_vec(33'h0_0000_0001);
      wait_result("t5_new", 23'h7FFFDF, 7'd1);

      // 6. reset with two vectors in flight
      bus.in_valid = 1'b1;
      bus.in_data  = 33'h1_0000_0003;
      tick();
      bus.in_data  = 33'h0_0000_0001;
      tick();
      bus.in_valid = 1'b0;
      chk("t6_inflight_valid", 64'(bus.out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 64'(bus.out_valid), 64'd0);
      chk("t6_async_z",     64'(bus.out_data),  64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      saw_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.out_valid === 1'b1) saw_valid = 1'b1;
      end
      chk("t6_no_pulse", 64'(saw_valid), 64'd0);
      send_vec(33'h1_0000_0003);
      wait_result("t6_cleared", 23'h000000, 7'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
